// File: rtl/mro_req_sched_if.sv
// Handshake and matrix-control bundle of the request scheduler.
// The master modport is the scheduler's view; slave is the ingress/egress/matrix side.
interface mro_req_sched_if #(
    parameter int unsigned NUM_ENTRIES = 4,
    parameter int unsigned DATA_W      = 32
);
    logic                   InValid;
    logic                   InIsRdRsp;
    logic [DATA_W-1:0]      InData;
    logic                   InReady;

    logic                   Out0Valid;
    logic                   Out0Ready;
    logic [DATA_W-1:0]      Out0Data;
    logic                   Out1Valid;
    logic                   Out1Ready;
    logic [DATA_W-1:0]      Out1Data;

    logic                   MroEnAlloc;
    logic [NUM_ENTRIES-1:0] MroNextAlloc;
    logic [NUM_ENTRIES-1:0] MroDealloc;
    logic [NUM_ENTRIES-1:0] MroMask0;
    logic [NUM_ENTRIES-1:0] MroMask1;
    logic [NUM_ENTRIES-1:0] MroOldest0;
    logic [NUM_ENTRIES-1:0] MroOldest1;

    modport master (
        input  InValid, InIsRdRsp, InData, Out0Ready, Out1Ready, MroOldest0, MroOldest1,
        output InReady, Out0Valid, Out0Data, Out1Valid, Out1Data,
               MroEnAlloc, MroNextAlloc, MroDealloc, MroMask0, MroMask1
    );

    modport slave (
        output InValid, InIsRdRsp, InData, Out0Ready, Out1Ready, MroOldest0, MroOldest1,
        input  InReady, Out0Valid, Out0Data, Out1Valid, Out1Data,
               MroEnAlloc, MroNextAlloc, MroDealloc, MroMask0, MroMask1
    );
endinterface

// File: rtl/mro_req_sched.sv
// Request-buffer controller: owns the payload slots, drives the external age matrix
// and issues the oldest read-response (port 0) and oldest other command (port 1).
module mro_req_sched #(
    parameter int unsigned  NUM_ENTRIES = 4,
    parameter int unsigned  DATA_W      = 32,
    localparam int unsigned OccW        = $clog2(NUM_ENTRIES + 1)
) (
    input  logic            Clk,
    input  logic            Rst,
    mro_req_sched_if.master bus,
    output logic [OccW-1:0] Occupancy,
    output logic            ProtErr
);
    logic [NUM_ENTRIES-1:0] entryValidQ, entryValidD;
    logic [NUM_ENTRIES-1:0] entryClsQ, entryClsD;
    logic [DATA_W-1:0]      entryDataQ [NUM_ENTRIES];
    logic [OccW-1:0]        occQ, occD;
    logic [1:0]             errQ, errD;

    logic [NUM_ENTRIES-1:0] freeVec, allocOh, deallocVec, mask0, mask1;
    logic [OccW-1:0]        deallocCnt;
    logic                   alloc, bad0, bad1, valid0, valid1, issue0, issue1;

    // Allocation: lowest free slot, from flopped state only so a slot freed this
    // cycle is not handed out again until the next one.
    always_comb begin
        freeVec = ~entryValidQ;
        allocOh = '0;
        for (int i = NUM_ENTRIES - 1; i >= 0; i--) begin
            if (freeVec[i]) begin
                allocOh    = '0;
                allocOh[i] = 1'b1;
            end
        end
        bus.InReady      = |freeVec;
        // Reset gate keeps the matrix controls quiet while Rst is held.
        alloc            = bus.InValid & bus.InReady & Rst;
        bus.MroEnAlloc   = alloc;
        bus.MroNextAlloc = alloc ? allocOh : '0;
    end

    // Issue side: class masks, protocol checks on the matrix answer, data muxes.
    always_comb begin
        mask0        = entryValidQ & ~entryClsQ;
        mask1        = entryValidQ & entryClsQ;
        bus.MroMask0 = mask0;
        bus.MroMask1 = mask1;

        bad0 = (|(bus.MroOldest0 & ~mask0)) |
               ((bus.MroOldest0 & (bus.MroOldest0 - NUM_ENTRIES'(1))) != '0);
        bad1 = (|(bus.MroOldest1 & ~mask1)) |
               ((bus.MroOldest1 & (bus.MroOldest1 - NUM_ENTRIES'(1))) != '0);

        valid0        = (|(bus.MroOldest0 & mask0)) & ~bad0 & ~errQ[0];
        valid1        = (|(bus.MroOldest1 & mask1)) & ~bad1 & ~errQ[1];
        bus.Out0Valid = valid0;
        bus.Out1Valid = valid1;

        bus.Out0Data = '0;
        bus.Out1Data = '0;
        for (int i = 0; i < NUM_ENTRIES; i++) begin
            bus.Out0Data = bus.Out0Data | (entryDataQ[i] & {DATA_W{bus.MroOldest0[i]}});
            bus.Out1Data = bus.Out1Data | (entryDataQ[i] & {DATA_W{bus.MroOldest1[i]}});
        end

        issue0         = valid0 & bus.Out0Ready;
        issue1         = valid1 & bus.Out1Ready;
        deallocVec     = ({NUM_ENTRIES{issue0}} & bus.MroOldest0) |
                         ({NUM_ENTRIES{issue1}} & bus.MroOldest1);
        bus.MroDealloc = deallocVec;
    end

    // Next-state for slot bookkeeping, occupancy and sticky per-port errors.
    always_comb begin
        entryValidD = (entryValidQ & ~deallocVec) | (alloc ? allocOh : '0);
        entryClsD   = entryClsQ;
        for (int i = 0; i < NUM_ENTRIES; i++) begin
            if (alloc && allocOh[i]) entryClsD[i] = ~bus.InIsRdRsp;
        end
        deallocCnt = '0;
        for (int i = 0; i < NUM_ENTRIES; i++) begin
            deallocCnt = deallocCnt + OccW'(deallocVec[i]);
        end
        occD = occQ + OccW'(alloc) - deallocCnt;
        errD = errQ | {bad1, bad0};
    end

    // Slot state, occupancy and error flags; all drop at once on reset.
    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            entryValidQ <= '0;
            entryClsQ   <= '0;
            occQ        <= '0;
            errQ        <= '0;
        end else begin
            entryValidQ <= entryValidD;
            entryClsQ   <= entryClsD;
            occQ        <= occD;
            errQ        <= errD;
        end
    end

    // Payload capture; contents are meaningless until the slot is valid, so no reset.
    always_ff @(posedge Clk) begin
        for (int i = 0; i < NUM_ENTRIES; i++) begin
            if (alloc && allocOh[i]) entryDataQ[i] <= bus.InData;
        end
    end

    assign Occupancy = occQ;
    assign ProtErr   = |errQ;
endmodule

// File: tb/tb_mro_req_sched.sv
// Bench for mro_req_sched: a small age-matrix model closes the loop, and a per-port
// scoreboard checks every issued payload against the order of acceptance.
module tb_mro_req_sched;
    localparam int unsigned NE = 4;
    localparam int unsigned DW = 32;

    logic           Clk = 1'b0;
    logic           Rst = 1'b0;
    logic [2:0]     Occupancy;
    logic           ProtErr;

    int nCmp = 0;
    int nErr = 0;

    logic [DW-1:0] exp0 [$];
    logic [DW-1:0] exp1 [$];

    logic                   force0En  = 1'b0;
    logic [NE-1:0]          force0Val = '0;
    logic [NE-1:0][NE-1:0]  older; // older[i][j]: slot i allocated before slot j

    mro_req_sched_if #(.NUM_ENTRIES(NE), .DATA_W(DW)) bus ();

    mro_req_sched #(.NUM_ENTRIES(NE), .DATA_W(DW)) dut (
        .Clk       (Clk),
        .Rst       (Rst),
        .bus       (bus),
        .Occupancy (Occupancy),
        .ProtErr   (ProtErr)
    );

    always #5 Clk = ~Clk;

    // Age-matrix model: a newly allocated slot is younger than every other slot.
    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            older <= '0;
        end else if (bus.MroEnAlloc) begin
            for (int j = 0; j < NE; j++) begin
                if (bus.MroNextAlloc[j]) begin
                    for (int i = 0; i < NE; i++) begin
                        if (i != j) begin
                            older[j][i] <= 1'b0;
                            older[i][j] <= 1'b1;
                        end
                    end
                end
            end
        end
    end

    function automatic logic [NE-1:0] oldestOf(input logic [NE-1:0] mask,
                                                input logic [NE-1:0][NE-1:0] ord);
        logic [NE-1:0] oh;
        oh = '0;
        for (int i = 0; i < NE; i++) begin
            oh[i] = mask[i];
            for (int j = 0; j < NE; j++) begin
                if (j != i && mask[j] && !ord[i][j]) oh[i] = 1'b0;
            end
        end
        return oh;
    endfunction

    assign bus.MroOldest0 = force0En ? force0Val : oldestOf(bus.MroMask0, older);
    assign bus.MroOldest1 = oldestOf(bus.MroMask1, older);

    task automatic checkVal(input string tag, input logic [63:0] got, input logic [63:0] exp);
        nCmp++;
        if (got !== exp) begin
            nErr++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Scoreboard: push on accepted request, pop and compare on every issue.
    always @(negedge Clk) begin
        if (Rst) begin
            if (bus.InValid && bus.InReady) begin
                if (bus.InIsRdRsp) exp0.push_back(bus.InData);
                else               exp1.push_back(bus.InData);
            end
            if (bus.Out0Valid && bus.Out0Ready) begin
                if (exp0.size() != 0) checkVal("port0 data", 64'(bus.Out0Data), 64'(exp0.pop_front()));
                else checkVal("port0 issue with empty scoreboard", 64'(bus.Out0Valid), 64'h0);
            end
            if (bus.Out1Valid && bus.Out1Ready) begin
                if (exp1.size() != 0) checkVal("port1 data", 64'(bus.Out1Data), 64'(exp1.pop_front()));
                else checkVal("port1 issue with empty scoreboard", 64'(bus.Out1Valid), 64'h0);
            end
        end
    end

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    task automatic push(input logic isRd, input logic [DW-1:0] data);
        bus.InValid   = 1'b1;
        bus.InIsRdRsp = isRd;
        bus.InData    = data;
        step();
        bus.InValid   = 1'b0;
    endtask

    task automatic drain(input string tag);
        bus.InValid   = 1'b0;
        bus.Out0Ready = 1'b1;
        bus.Out1Ready = 1'b1;
        for (int i = 0; i < 20; i++) begin
            step();
            if (Occupancy == 0) break;
        end
        checkVal(tag, 64'(Occupancy), 64'h0);
        bus.Out0Ready = 1'b0;
        bus.Out1Ready = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        bus.InValid   = 1'b0;
        bus.InIsRdRsp = 1'b0;
        bus.InData    = '0;
        bus.Out0Ready = 1'b0;
        bus.Out1Ready = 1'b0;

        // Reset state
        #1;
        checkVal("rst InReady",   64'(bus.InReady),      64'h1);
        checkVal("rst Out0Valid", 64'(bus.Out0Valid),    64'h0);
        checkVal("rst Out1Valid", 64'(bus.Out1Valid),    64'h0);
        checkVal("rst EnAlloc",   64'(bus.MroEnAlloc),   64'h0);
        checkVal("rst Dealloc",   64'(bus.MroDealloc),   64'h0);
        checkVal("rst Occupancy", 64'(Occupancy),        64'h0);
        checkVal("rst ProtErr",   64'(ProtErr),          64'h0);
        step();
        Rst = 1'b1;
        step();

        // Single read response, minimum latency
        bus.InValid = 1'b1; bus.InIsRdRsp = 1'b1; bus.InData = 32'hA5;
        @(negedge Clk);
        checkVal("t1 EnAlloc",   64'(bus.MroEnAlloc),   64'h1);
        checkVal("t1 NextAlloc", 64'(bus.MroNextAlloc), 64'h1);
        step();
        bus.InValid = 1'b0; bus.Out0Ready = 1'b1;
        @(negedge Clk);
        checkVal("t1 Out0Valid", 64'(bus.Out0Valid),  64'h1);
        checkVal("t1 Out0Data",  64'(bus.Out0Data),   64'hA5);
        checkVal("t1 Dealloc",   64'(bus.MroDealloc), 64'h1);
        step();
        bus.Out0Ready = 1'b0;
        checkVal("t1 Occupancy", 64'(Occupancy), 64'h0);

        // Fill with class-1, refuse a fifth, then drain in order
        for (int i = 0; i < 4; i++) begin
            bus.InValid = 1'b1; bus.InIsRdRsp = 1'b0; bus.InData = 32'hD0 + i;
            @(negedge Clk);
            checkVal("t2 NextAlloc", 64'(bus.MroNextAlloc), 64'(1) << i);
            step();
        end
        bus.InValid = 1'b1; bus.InData = 32'hDEAD;
        @(negedge Clk);
        checkVal("t2 full InReady", 64'(bus.InReady),    64'h0);
        checkVal("t2 full EnAlloc", 64'(bus.MroEnAlloc), 64'h0);
        checkVal("t2 Occupancy",    64'(Occupancy),      64'h4);
        step();
        bus.InValid = 1'b0; bus.Out1Ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge Clk);
            checkVal("t2 Out1Valid", 64'(bus.Out1Valid),  64'h1);
            checkVal("t2 Dealloc",   64'(bus.MroDealloc), 64'(1) << i);
            step();
        end
        bus.Out1Ready = 1'b0;
        checkVal("t2 empty Occupancy", 64'(Occupancy), 64'h0);

        // Interleaved classes, both ports issue together
        push(1'b1, 32'h100);
        push(1'b0, 32'h200);
        push(1'b1, 32'h101);
        bus.Out0Ready = 1'b1; bus.Out1Ready = 1'b1;
        @(negedge Clk);
        checkVal("t3 Out0Data", 64'(bus.Out0Data),   64'h100);
        checkVal("t3 Out1Data", 64'(bus.Out1Data),   64'h200);
        checkVal("t3 Dealloc",  64'(bus.MroDealloc), 64'h3);
        step();
        @(negedge Clk);
        checkVal("t3 Out0Data next", 64'(bus.Out0Data),   64'h101);
        checkVal("t3 Dealloc next",  64'(bus.MroDealloc), 64'h4);
        checkVal("t3 Out1Valid",     64'(bus.Out1Valid),  64'h0);
        drain("t3 drain");

        // Full buffer: issue and request in the same cycle
        for (int i = 0; i < 4; i++) push(1'b0, 32'h300 + i);
        bus.InValid = 1'b1; bus.InIsRdRsp = 1'b1; bus.InData = 32'h3E4; bus.Out1Ready = 1'b1;
        @(negedge Clk);
        checkVal("t4 InReady",  64'(bus.InReady),    64'h0);
        checkVal("t4 EnAlloc",  64'(bus.MroEnAlloc), 64'h0);
        checkVal("t4 Dealloc",  64'(bus.MroDealloc), 64'h1);
        step();
        bus.Out1Ready = 1'b0;
        @(negedge Clk);
        checkVal("t4 reuse EnAlloc",   64'(bus.MroEnAlloc),   64'h1);
        checkVal("t4 reuse NextAlloc", 64'(bus.MroNextAlloc), 64'h1);
        step();
        bus.InValid = 1'b0;
        checkVal("t4 Occupancy", 64'(Occupancy), 64'h4);
        drain("t4 drain");

        // Stalled port 0 stays stable while younger entries arrive
        push(1'b1, 32'h500);
        for (int c = 0; c < 5; c++) begin
            bus.InValid = 1'b1; bus.InIsRdRsp = 1'b1; bus.InData = 32'h501 + c;
            @(negedge Clk);
            checkVal("t5 Out0Valid", 64'(bus.Out0Valid), 64'h1);
            checkVal("t5 Out0Data",  64'(bus.Out0Data),  64'h500);
            step();
        end
        bus.InValid = 1'b0;
        checkVal("t5 Occupancy", 64'(Occupancy), 64'h4);
        drain("t5 drain");
        checkVal("sb0 leftover", 64'(exp0.size()), 64'h0);
        checkVal("sb1 leftover", 64'(exp1.size()), 64'h0);

        // Matrix points at an invalid slot: sticky error, no issue
        push(1'b1, 32'h77);
        force0En = 1'b1; force0Val = 4'b0010;
        @(negedge Clk);
        checkVal("t6 Out0Valid",   64'(bus.Out0Valid), 64'h0);
        checkVal("t6 ProtErr pre", 64'(ProtErr),       64'h0);
        step();
        checkVal("t6 ProtErr set", 64'(ProtErr), 64'h1);
        step();
        force0En = 1'b0;
        step();
        checkVal("t6 ProtErr sticky", 64'(ProtErr), 64'h1);

        // Asynchronous reset with work pending
        push(1'b0, 32'h88);
        @(posedge Clk);
        #2;
        Rst = 1'b0;
        #1;
        checkVal("t7 Occupancy", 64'(Occupancy),     64'h0);
        checkVal("t7 InReady",   64'(bus.InReady),   64'h1);
        checkVal("t7 Out0Valid", 64'(bus.Out0Valid), 64'h0);
        checkVal("t7 Out1Valid", 64'(bus.Out1Valid), 64'h0);
        checkVal("t7 Mask0",     64'(bus.MroMask0),  64'h0);
        checkVal("t7 Mask1",     64'(bus.MroMask1),  64'h0);
        checkVal("t7 ProtErr",   64'(ProtErr),       64'h0);
        exp0.delete();
        exp1.delete();
        step();
        Rst = 1'b1;
        step();
        checkVal("t7 post InReady",   64'(bus.InReady), 64'h1);
        checkVal("t7 post Occupancy", 64'(Occupancy),   64'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nErr);
        $finish;
    end
endmodule
